// File: rtl/jogada_capture_if.sv
// Button/jogada bundle between the player input side and the capture block.
// The capture block owns the slave view; whoever drives the buttons owns the master view.
interface jogada_capture_if #(
    parameter int WIDTH = 4
);
    logic             limpa;
    logic [WIDTH-1:0] botoes;
    logic [WIDTH-1:0] jogada;
    logic             jogada_feita;
    logic             jogada_valida;
    logic             ativo;

    modport master (
        output limpa,
        output botoes,
        input  jogada,
        input  jogada_feita,
        input  jogada_valida,
        input  ativo
    );

    modport slave (
        input  limpa,
        input  botoes,
        output jogada,
        output jogada_feita,
        output jogada_valida,
        output ativo
    );
endinterface

// File: rtl/jogada_capture.sv
// Debounced capture of the player's button press for the memory game.
// Holds the accepted pattern for the datapath mux D1 input and pulses once per press.
module jogada_capture #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic             clock,
    input  logic             reset,
    jogada_capture_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] N_C = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEB  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n, cnt_inc;
    logic [WIDTH-1:0] cand, cand_n;
    logic [WIDTH-1:0] jogada, jogada_n;
    logic             feita, feita_n;
    logic             valida, valida_n;
    logic             ativo, ativo_n;
    logic             accept;
    logic [WIDTH-1:0] acc_pat;

    function automatic logic onehot(input logic [WIDTH-1:0] p);
        return (p != '0) && ((p & (p - 1'b1)) == '0);
    endfunction

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cand_n   = cand;
        jogada_n = jogada;
        feita_n  = 1'b0;
        valida_n = valida;
        ativo_n  = ativo;
        accept   = 1'b0;
        acc_pat  = cand;

        unique case (state)
            IDLE: begin
                if (bus.botoes != '0) begin
                    cand_n = bus.botoes;
                    cnt_n  = CW'(1);
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept  = 1'b1;
                        acc_pat = bus.botoes;
                    end else begin
                        state_n = DEB;
                    end
                end
            end
            DEB: begin
                // Any deviation drops back to IDLE; the new pattern is taken next edge
                if (bus.botoes != cand) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == N_C) accept = 1'b1;
                end
            end
            REL: begin
                if (bus.botoes == '0) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == N_C) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        ativo_n = 1'b0;
                    end
                end else begin
                    cnt_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        if (accept) begin
            state_n  = REL;
            cnt_n    = '0;
            ativo_n  = 1'b1;
            jogada_n = acc_pat;
            feita_n  = 1'b1;
            valida_n = onehot(acc_pat);
        end

        // Clear beats a simultaneous accept but leaves the FSM alone
        if (bus.limpa) begin
            jogada_n = '0;
            valida_n = 1'b0;
            feita_n  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            cand   <= '0;
            jogada <= '0;
            feita  <= 1'b0;
            valida <= 1'b0;
            ativo  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            cand   <= cand_n;
            jogada <= jogada_n;
            feita  <= feita_n;
            valida <= valida_n;
            ativo  <= ativo_n;
        end
    end

    assign bus.jogada        = jogada;
    assign bus.jogada_feita  = feita;
    assign bus.jogada_valida = valida;
    assign bus.ativo         = ativo;
endmodule

// File: tb/tb_jogada_capture.sv
// Bench for jogada_capture: vector table for the basic flows,
// hand sequences for hold/release, limpa on accept and reset mid-debounce.
module tb_jogada_capture;
    logic clock;
    logic reset;

    jogada_capture_if #(.WIDTH(4)) bus ();

    jogada_capture #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       limpa;
        logic [3:0] botoes;
        logic [3:0] jogada;
        logic       feita;
        logic       valida;
        logic       ativo;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    task automatic add(input string nm, input logic r, input logic l,
                       input logic [3:0] b, input logic [3:0] j,
                       input logic f, input logic v, input logic a);
        vec_t t;
        t.name   = nm;
        t.rst_n  = r;
        t.limpa  = l;
        t.botoes = b;
        t.jogada = j;
        t.feita  = f;
        t.valida = v;
        t.ativo  = a;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic apply(input logic r, input logic l, input logic [3:0] b);
        reset      = r;
        bus.limpa  = l;
        bus.botoes = b;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [3:0] j,
                           input logic f, input logic v, input logic a);
        chk({nm, ".jogada"}, bus.jogada, j);
        chk({nm, ".feita"}, {3'b0, bus.jogada_feita}, {3'b0, f});
        chk({nm, ".valida"}, {3'b0, bus.jogada_valida}, {3'b0, v});
        chk({nm, ".ativo"}, {3'b0, bus.ativo}, {3'b0, a});
    endtask

    initial begin
        int pulses;
        logic exp_ativo [6];
        logic [3:0] relpat [6];

        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        bus.limpa  = 1'b0;
        bus.botoes = 4'b0;

        add("rst_a",  0, 0, 4'b0010, 4'b0000, 0, 0, 0);
        add("rst_b",  0, 0, 4'b0010, 4'b0000, 0, 0, 0);
        add("press1", 1, 0, 4'b0100, 4'b0000, 0, 0, 0);
        add("press2", 1, 0, 4'b0100, 4'b0000, 0, 0, 0);
        add("press3", 1, 0, 4'b0100, 4'b0100, 1, 1, 1);
        add("hold",   1, 0, 4'b0100, 4'b0100, 0, 1, 1);
        add("rel1",   1, 0, 4'b0000, 4'b0100, 0, 1, 1);
        add("rel2",   1, 0, 4'b0000, 4'b0100, 0, 1, 1);
        add("rel3",   1, 0, 4'b0000, 4'b0100, 0, 1, 0);
        add("bnc1",   1, 0, 4'b0100, 4'b0100, 0, 1, 0);
        add("bnc0",   1, 0, 4'b0000, 4'b0100, 0, 1, 0);
        add("bnc2",   1, 0, 4'b0100, 4'b0100, 0, 1, 0);
        add("bnc3",   1, 0, 4'b0100, 4'b0100, 0, 1, 0);
        add("bnc4",   1, 0, 4'b0100, 4'b0100, 1, 1, 1);
        add("brel1",  1, 0, 4'b0000, 4'b0100, 0, 1, 1);
        add("brel2",  1, 0, 4'b0000, 4'b0100, 0, 1, 1);
        add("brel3",  1, 0, 4'b0000, 4'b0100, 0, 1, 0);
        add("two1",   1, 0, 4'b0011, 4'b0100, 0, 1, 0);
        add("two2",   1, 0, 4'b0011, 4'b0100, 0, 1, 0);
        add("two3",   1, 0, 4'b0011, 4'b0011, 1, 0, 1);
        add("trel1",  1, 0, 4'b0000, 4'b0011, 0, 0, 1);
        add("trel2",  1, 0, 4'b0000, 4'b0011, 0, 0, 1);
        add("trel3",  1, 0, 4'b0000, 4'b0011, 0, 0, 0);
        add("clr",    1, 1, 4'b0000, 4'b0000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst_n, vecs[i].limpa, vecs[i].botoes);
            chk_all(vecs[i].name, vecs[i].jogada, vecs[i].feita,
                    vecs[i].valida, vecs[i].ativo);
        end

        // Long hold: exactly one pulse, on the third edge
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1, 0, 4'b0001);
            if (bus.jogada_feita) pulses++;
            if (i == 2) chk("hold.first_pulse", {3'b0, bus.jogada_feita}, 4'd1);
        end
        chk("hold.pulses", pulses[3:0], 4'd1);
        chk_all("hold.end", 4'b0001, 0, 1, 1);

        relpat    = '{4'b0, 4'b0, 4'b0001, 4'b0, 4'b0, 4'b0};
        exp_ativo = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            apply(1, 0, relpat[i]);
            chk($sformatf("rel_bounce%0d.ativo", i),
                {3'b0, bus.ativo}, {3'b0, exp_ativo[i]});
        end

        apply(1, 0, 4'b1000);
        apply(1, 0, 4'b1000);
        chk("repress.early", {3'b0, bus.jogada_feita}, 4'd0);
        apply(1, 0, 4'b1000);
        chk_all("repress", 4'b1000, 1, 1, 1);
        for (int i = 0; i < 3; i++) apply(1, 0, 4'b0000);
        chk("repress.released", {3'b0, bus.ativo}, 4'd0);

        // limpa coinciding with the accept edge
        apply(1, 0, 4'b0010);
        apply(1, 0, 4'b0010);
        apply(1, 1, 4'b0010);
        chk_all("limpa_acc", 4'b0000, 0, 0, 1);
        apply(1, 0, 4'b0010);
        chk_all("limpa_after", 4'b0000, 0, 0, 1);
        for (int i = 0; i < 3; i++) apply(1, 0, 4'b0000);
        chk("limpa.released", {3'b0, bus.ativo}, 4'd0);

        // Reset in the middle of a debounce
        apply(1, 0, 4'b0100);
        apply(1, 0, 4'b0100);
        apply(1, 0, 4'b0100);
        chk_all("pre_rst", 4'b0100, 1, 1, 1);
        for (int i = 0; i < 3; i++) apply(1, 0, 4'b0000);
        apply(1, 0, 4'b0001);
        apply(1, 0, 4'b0001);
        apply(0, 0, 4'b0001);
        chk_all("rst_deb", 4'b0000, 0, 0, 0);
        apply(1, 0, 4'b0001);
        apply(1, 0, 4'b0001);
        chk_all("post_rst2", 4'b0000, 0, 0, 0);
        apply(1, 0, 4'b0001);
        chk_all("post_rst3", 4'b0001, 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
